// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: core state codes, initial hash values, round
// constants and the message padder's state encodings.
package sha256_pkg;

    localparam logic [2:0] CORE_IDLE       = 3'h0;
    localparam logic [2:0] CORE_LOAD_CHUNK = 3'h1;
    localparam logic [2:0] CORE_INIT_H     = 3'h2;
    localparam logic [2:0] CORE_EXPAND     = 3'h3;
    localparam logic [2:0] CORE_ROUND      = 3'h4;
    localparam logic [2:0] CORE_ADD_H      = 3'h5;
    localparam logic [2:0] CORE_HASH       = 3'h6;
    localparam logic [2:0] CORE_DONE       = 3'h7;

    localparam logic [31:0] SHA256_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        ST_FILL,
        ST_EMIT_DATA,
        ST_EMIT_FINAL,
        ST_EMIT_LENBLK
    } pad_state_t;

    // What follows an EMIT_DATA block once it has been handed over
    typedef enum logic [1:0] {
        NXT_FILL,
        NXT_PADBLK,
        NXT_LENBLK
    } pad_next_t;

endpackage

// File: rtl/sha256_msg_padder.sv
// Byte-stream to FIPS 180-4 padded 512-bit chunk converter feeding the SHA-256 core.
// Chunks carry first/last flags so the controller knows when to re-init and when to finish.
import sha256_pkg::*;

module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] chunk,
    output logic         chunk_first,
    output logic         chunk_last
);

    pad_state_t       state_q, state_d;
    pad_next_t        next_q, next_d;
    logic [5:0]       idx_q, idx_d;
    logic [LEN_W-1:0] bitlen_q, bitlen_d;
    logic             first_pend_q, first_pend_d;
    logic [511:0]     buf_q, buf_d;
    logic             out_valid_q, out_valid_d;
    logic [511:0]     chunk_q, chunk_d;
    logic             chunk_first_q, chunk_first_d;
    logic             chunk_last_q, chunk_last_d;

    logic             accept;
    logic [6:0]       n;
    logic [LEN_W-1:0] bitlen_inc;
    logic [63:0]      len_new;
    logic [63:0]      len_cur;
    logic [511:0]     data_blk;
    logic [511:0]     mark_blk;

    assign in_ready   = reset && (state_q == ST_FILL);
    assign accept     = in_valid && in_ready;
    assign n          = {1'b0, idx_q} + 7'd1;
    assign bitlen_inc = bitlen_q + LEN_W'(8);
    assign len_new    = 64'(bitlen_inc);
    assign len_cur    = 64'(bitlen_q);

    // Lanes past the write index are already zero, so only lane n needs the marker
    for (genvar i = 0; i < 64; i++) begin : g_lane
        assign data_blk[511-8*i -: 8] = (accept && idx_q == 6'(i)) ? in_byte : buf_q[511-8*i -: 8];
        assign mark_blk[511-8*i -: 8] = (n == 7'(i)) ? 8'h80 : data_blk[511-8*i -: 8];
    end

    always_comb begin
        state_d       = state_q;
        next_d        = next_q;
        idx_d         = idx_q;
        bitlen_d      = bitlen_q;
        first_pend_d  = first_pend_q;
        buf_d         = buf_q;
        out_valid_d   = out_valid_q;
        chunk_d       = chunk_q;
        chunk_first_d = chunk_first_q;
        chunk_last_d  = chunk_last_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    buf_d    = data_blk;
                    idx_d    = idx_q + 6'd1;
                    bitlen_d = bitlen_inc;
                    if (in_last || n == 7'd64) begin
                        out_valid_d   = 1'b1;
                        chunk_first_d = first_pend_q;
                        chunk_last_d  = 1'b0;
                        buf_d         = '0;
                        idx_d         = '0;
                        state_d       = ST_EMIT_DATA;
                        next_d        = NXT_FILL;
                        chunk_d       = data_blk;
                        if (in_last) begin
                            if (n == 7'd64) begin
                                next_d = NXT_PADBLK;
                            end else if (n <= 7'd55) begin
                                chunk_d      = mark_blk | {448'b0, len_new};
                                chunk_last_d = 1'b1;
                                state_d      = ST_EMIT_FINAL;
                            end else begin
                                chunk_d = mark_blk;
                                next_d  = NXT_LENBLK;
                            end
                        end
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    first_pend_d = chunk_last_q;
                    // A trailing pad-only or length-only block follows without dropping out_valid
                    if (state_q == ST_EMIT_DATA && next_q != NXT_FILL) begin
                        chunk_first_d = 1'b0;
                        chunk_last_d  = 1'b1;
                        if (next_q == NXT_PADBLK) begin
                            chunk_d = {8'h80, 440'b0, len_cur};
                            state_d = ST_EMIT_FINAL;
                        end else begin
                            chunk_d = {448'b0, len_cur};
                            state_d = ST_EMIT_LENBLK;
                        end
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = ST_FILL;
                        if (chunk_last_q) begin
                            bitlen_d = '0;
                            idx_d    = '0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_FILL;
            next_q        <= NXT_FILL;
            idx_q         <= '0;
            bitlen_q      <= '0;
            first_pend_q  <= 1'b1;
            buf_q         <= '0;
            out_valid_q   <= 1'b0;
            chunk_q       <= '0;
            chunk_first_q <= 1'b0;
            chunk_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            next_q        <= next_d;
            idx_q         <= idx_d;
            bitlen_q      <= bitlen_d;
            first_pend_q  <= first_pend_d;
            buf_q         <= buf_d;
            out_valid_q   <= out_valid_d;
            chunk_q       <= chunk_d;
            chunk_first_q <= chunk_first_d;
            chunk_last_q  <= chunk_last_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign chunk       = chunk_q;
    assign chunk_first = chunk_first_q;
    assign chunk_last  = chunk_last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: a table of messages checked against a
// reference padding built from the message bytes, plus reset and "abc" sequences.
module tb_sha256_msg_padder;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_byte;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] chunk;
    logic         chunk_first;
    logic         chunk_last;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [511:0] ABC_CHUNK = {32'h61626380, 416'h0, 64'h18};

    typedef struct {
        string       name;
        int          len;
        int          pat;
        int          stall;
        int          exp_chunks;
        logic [63:0] exp_len;
    } msg_vec_t;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .chunk       (chunk),
        .chunk_first (chunk_first),
        .chunk_last  (chunk_last)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int pat, input int i);
        case (pat)
            0:       msg_byte = 8'h00;
            1:       msg_byte = 8'h41;
            2:       msg_byte = 8'(i);
            default: msg_byte = 8'(8'h61 + i);
        endcase
    endfunction

    // Reference padding: message, 0x80, zeros, then 64-bit big-endian bit length at the end
    function automatic logic [7:0] padded_byte(input int len, input int pat, input int total, input int j);
        logic [63:0] l64;
        int p;
        l64 = 64'(len) * 64'd8;
        if (j < len) return msg_byte(pat, j);
        if (j == len) return 8'h80;
        if (j >= total - 8) begin
            p = j - (total - 8);
            return l64[63-8*p -: 8];
        end
        return 8'h00;
    endfunction

    function automatic logic [511:0] model_chunk(input int len, input int pat, input int nch, input int k);
        logic [511:0] c;
        for (int b = 0; b < 64; b++)
            c[511-8*b -: 8] = padded_byte(len, pat, nch * 64, 64 * k + b);
        return c;
    endfunction

    // Streams one message and collects its chunks, optionally stalling out_ready
    task automatic apply_stimulus(input msg_vec_t v);
        int pos = 0;
        int k = 0;
        int stall_cnt = 0;
        int cycles = 0;
        logic [511:0] exp;
        logic [63:0] last_len = '0;
        while (k < v.exp_chunks && cycles < 2000) begin
            @(negedge clock);
            cycles++;
            if (out_valid) begin
                exp = model_chunk(v.len, v.pat, v.exp_chunks, k);
                check_output({v.name, " chunk"}, chunk, exp);
                check_output({v.name, " first"}, 512'(chunk_first), 512'(k == 0));
                check_output({v.name, " last"}, 512'(chunk_last), 512'(k == v.exp_chunks - 1));
                check_output({v.name, " in_ready during emit"}, 512'(in_ready), 512'(0));
                if (pos < v.len) begin
                    in_valid = 1'b1;
                    in_byte  = msg_byte(v.pat, pos);
                    in_last  = (pos == v.len - 1);
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b1;
                end
                if (stall_cnt < v.stall) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                    last_len  = chunk[63:0];
                    stall_cnt = 0;
                    k++;
                end
            end else begin
                out_ready = 1'b0;
                if (in_ready && pos < v.len) begin
                    in_valid = 1'b1;
                    in_byte  = msg_byte(v.pat, pos);
                    in_last  = (pos == v.len - 1);
                    pos++;
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b1;
                end
            end
        end
        if (k < v.exp_chunks) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s timeout: got %0d chunks expected %0d", v.name, k, v.exp_chunks);
        end
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check_output({v.name, " length field"}, 512'(last_len), 512'(v.exp_len));
        check_output({v.name, " idle out_valid"}, 512'(out_valid), 512'(0));
        check_output({v.name, " idle in_ready"}, 512'(in_ready), 512'(1));
    endtask

    task automatic send_bytes(input int count, input int pat);
        for (int i = 0; i < count; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_byte  = msg_byte(pat, i);
            in_last  = 1'b0;
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        check_output({name, " out_valid"}, 512'(out_valid), 512'(0));
        check_output({name, " chunk"}, chunk, 512'(0));
        check_output({name, " chunk_first"}, 512'(chunk_first), 512'(0));
        check_output({name, " chunk_last"}, 512'(chunk_last), 512'(0));
        check_output({name, " in_ready low"}, 512'(in_ready), 512'(0));
    endtask

    task automatic check_abc(input string name);
        msg_vec_t v;
        int cycles = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_byte  = msg_byte(3, i);
            in_last  = (i == 2);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_output({name, " latency out_valid"}, 512'(out_valid), 512'(1));
        while (!out_valid && cycles < 20) begin
            @(negedge clock);
            cycles++;
        end
        check_output({name, " chunk"}, chunk, ABC_CHUNK);
        check_output({name, " first"}, 512'(chunk_first), 512'(1));
        check_output({name, " last"}, 512'(chunk_last), 512'(1));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check_output({name, " released"}, 512'({out_valid, in_ready}), 512'(2'b01));
        v.name = "";
    endtask

    msg_vec_t vecs [0:6];

    initial begin
        vecs[0] = '{name: "abc",      len: 3,   pat: 3, stall: 0, exp_chunks: 1, exp_len: 64'h18};
        vecs[1] = '{name: "zeros55",  len: 55,  pat: 0, stall: 0, exp_chunks: 1, exp_len: 64'h1B8};
        vecs[2] = '{name: "a56",      len: 56,  pat: 1, stall: 0, exp_chunks: 2, exp_len: 64'h1C0};
        vecs[3] = '{name: "inc64",    len: 64,  pat: 2, stall: 0, exp_chunks: 2, exp_len: 64'h200};
        vecs[4] = '{name: "inc130",   len: 130, pat: 2, stall: 5, exp_chunks: 3, exp_len: 64'h410};
        vecs[5] = '{name: "inc63",    len: 63,  pat: 2, stall: 2, exp_chunks: 2, exp_len: 64'h1F8};
        vecs[6] = '{name: "one_byte", len: 1,   pat: 1, stall: 0, exp_chunks: 1, exp_len: 64'h8};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_state("reset");
        reset = 1'b1;
        @(negedge clock);
        check_output("ready after reset", 512'(in_ready), 512'(1));

        for (int i = 0; i < 7; i++)
            apply_stimulus(vecs[i]);

        send_bytes(20, 2);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state("mid-message reset");
        reset = 1'b1;
        check_abc("abc after reset");

        apply_stimulus(vecs[3]);
        send_bytes(64, 1);
        check_output("mid-emit out_valid", 512'(out_valid), 512'(1));
        reset = 1'b0;
        @(negedge clock);
        check_reset_state("mid-emit reset");
        reset = 1'b1;
        check_abc("abc after emit reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
